mod_n_updown_counter: RTL and testbench

- Parametrised modulo-N binary counter. Successor to the fixed up-only N-bit counter.
- Adds up/down direction, count enable, synchronous clear, parallel load, a one-shot (stop-at-terminal) mode and wrap/terminal-count flags.
- Used as a timing/sequencing primitive by datapath and FSM blocks in the digital logic library.
- MOD_VALUE is not required to be a power of two.

---
 rtl/mod_n_updown_counter_if.sv | 28 ++
 rtl/mod_n_updown_counter.sv | 82 ++++++++
 tb/tb_mod_n_updown_counter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle for mod_n_updown_counter; master drives controls, slave is the counter.
interface mod_n_updown_counter_if #(
  parameter int unsigned MOD_VALUE = 8
);
  localparam int unsigned W = $clog2(MOD_VALUE);

  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         up_dn;
  logic         oneshot;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap;
  logic         done;
  logic         load_err;

  modport master (
    output clr, load, load_val, en, up_dn, oneshot,
    input  count, tc, wrap, done, load_err
  );

  modport slave (
    input  clr, load, load_val, en, up_dn, oneshot,
    output count, tc, wrap, done, load_err
  );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with clear, load, one-shot halt and wrap/terminal flags.
// Define MOD_COUNTER_SATURATE_EN to saturate at the terminal value in free-run mode.
module mod_n_updown_counter #(
  parameter int unsigned MOD_VALUE = 8
) (
  input logic                    clk,
  input logic                    rst,
  mod_n_updown_counter_if.slave  bus_io
);
  localparam int unsigned W = $clog2(MOD_VALUE);
  localparam logic [W-1:0] MaxCount = W'(MOD_VALUE - 1);

  typedef enum logic {StRun, StHalt} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         done_q, done_d;
  logic         load_err_q, load_err_d;
  logic         at_term;

  assign at_term = bus_io.up_dn ? (count_q == MaxCount) : (count_q == '0);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    done_d     = done_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus_io.clr) begin
      state_d = StRun;
      count_d = '0;
      done_d  = 1'b0;
    end else if (bus_io.load) begin
      state_d = StRun;
      done_d  = 1'b0;
      if (32'(bus_io.load_val) < MOD_VALUE) begin
        count_d = bus_io.load_val;
      end else begin
        count_d    = '0;
        load_err_d = 1'b1;
      end
    end else if (bus_io.en && (state_q == StRun)) begin
      if (!at_term) begin
        count_d = bus_io.up_dn ? count_q + W'(1) : count_q - W'(1);
      end else if (bus_io.oneshot) begin
        state_d = StHalt;
        done_d  = 1'b1;
      end else begin
`ifdef MOD_COUNTER_SATURATE_EN
        count_d = count_q;
`else
        // Explicit wrap targets keep non-power-of-two moduli in range.
        count_d = bus_io.up_dn ? '0 : MaxCount;
        wrap_d  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus_io.count    = count_q;
  assign bus_io.tc       = bus_io.en && at_term;
  assign bus_io.wrap     = wrap_q;
  assign bus_io.done     = done_q;
  assign bus_io.load_err = load_err_q;
endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter: MOD_VALUE=8 and MOD_VALUE=10 instances share one stimulus
// stream and are compared against a modular-arithmetic reference model.
module tb_mod_n_updown_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0, load = 1'b0, en = 1'b0, up_dn = 1'b1, oneshot = 1'b0;
  int   lv = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef MOD_COUNTER_SATURATE_EN
  localparam bit Saturate = 1'b1;
`else
  localparam bit Saturate = 1'b0;
`endif

  always #5 clk = ~clk;

  mod_n_updown_counter_if #(.MOD_VALUE(8))  if8 ();
  mod_n_updown_counter_if #(.MOD_VALUE(10)) if10 ();

  assign if8.clr = clr;       assign if10.clr = clr;
  assign if8.load = load;     assign if10.load = load;
  assign if8.en = en;         assign if10.en = en;
  assign if8.up_dn = up_dn;   assign if10.up_dn = up_dn;
  assign if8.oneshot = oneshot;
  assign if10.oneshot = oneshot;
  assign if8.load_val = lv[2:0];
  assign if10.load_val = lv[3:0];

  mod_n_updown_counter #(.MOD_VALUE(8)) dut8 (.clk(clk), .rst(rst), .bus_io(if8));
  mod_n_updown_counter #(.MOD_VALUE(10)) dut10 (.clk(clk), .rst(rst), .bus_io(if10));

  logic [3:0] cnt_o [2];
  logic       tc_o [2], wrap_o [2], done_o [2], lerr_o [2];
  assign cnt_o[0] = {1'b0, if8.count};  assign cnt_o[1] = if10.count;
  assign tc_o[0] = if8.tc;              assign tc_o[1] = if10.tc;
  assign wrap_o[0] = if8.wrap;          assign wrap_o[1] = if10.wrap;
  assign done_o[0] = if8.done;          assign done_o[1] = if10.done;
  assign lerr_o[0] = if8.load_err;      assign lerr_o[1] = if10.load_err;

  // Reference model: index 0 is modulus 8, index 1 is modulus 10.
  int m_cnt [2];
  bit m_halt [2], m_done [2], m_wrap [2], m_lerr [2];

  function automatic int modn(int i);
    return (i == 0) ? 8 : 10;
  endfunction

  function automatic bit exp_tc(int i);
    return en && (up_dn ? (m_cnt[i] == modn(i) - 1) : (m_cnt[i] == 0));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_halt[i] = 0; m_done[i] = 0; m_wrap[i] = 0; m_lerr[i] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      int n, li, term;
      n    = modn(i);
      li   = (i == 0) ? (lv % 8) : (lv % 16);
      term = up_dn ? n - 1 : 0;
      m_wrap[i] = 0;
      m_lerr[i] = 0;
      if (clr) begin
        m_cnt[i] = 0; m_halt[i] = 0; m_done[i] = 0;
      end else if (load) begin
        if (li < n) m_cnt[i] = li;
        else begin
          m_cnt[i] = 0; m_lerr[i] = 1;
        end
        m_halt[i] = 0; m_done[i] = 0;
      end else if (en && !m_halt[i]) begin
        if (m_cnt[i] == term && oneshot) begin
          m_halt[i] = 1; m_done[i] = 1;
        end else if (!(m_cnt[i] == term && Saturate)) begin
          m_wrap[i] = (m_cnt[i] == term);
          m_cnt[i]  = (m_cnt[i] + (up_dn ? 1 : n - 1)) % n;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cnt_o[i] !== 4'd0 || wrap_o[i] !== 1'b0 || done_o[i] !== 1'b0 || lerr_o[i] !== 1'b0)
      begin
        errors++;
        $display("FAIL reset[%0d]: got cnt=%0d wrap=%b done=%b lerr=%b want all zero",
                 i, cnt_o[i], wrap_o[i], done_o[i], lerr_o[i]);
      end
    end
    rst = 1'b0;
    model_reset();
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cnt_o[i] !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %0d want 0", i, cnt_o[i]);
      end
    end
  endtask

  task automatic test_up_wrap();
    en = 1'b1; up_dn = 1'b1; oneshot = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (cnt_o[0] !== 4'(m_cnt[0]) || tc_o[0] !== exp_tc(0) || wrap_o[0] !== m_wrap[0]) begin
        errors++;
        $display("FAIL up_wrap step %0d: got cnt=%0d tc=%b wrap=%b want cnt=%0d tc=%b wrap=%b",
                 k, cnt_o[0], tc_o[0], wrap_o[0], m_cnt[0], exp_tc(0), m_wrap[0]);
      end
    end
  endtask

  task automatic test_down_wrap();
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1; up_dn = 1'b0; oneshot = 1'b0;
    for (int k = 0; k < 23; k++) begin
      tick();
      checks++;
      if (cnt_o[1] !== 4'(m_cnt[1]) || tc_o[1] !== exp_tc(1) || wrap_o[1] !== m_wrap[1]
          || cnt_o[1] > 4'd9) begin
        errors++;
        $display("FAIL down_wrap step %0d: got cnt=%0d tc=%b wrap=%b want cnt=%0d tc=%b wrap=%b",
                 k, cnt_o[1], tc_o[1], wrap_o[1], m_cnt[1], exp_tc(1), m_wrap[1]);
      end
    end
  endtask

  task automatic test_oneshot();
    lv = 5; load = 1'b1; en = 1'b1; tick(); load = 1'b0;
    checks++;
    if (cnt_o[0] !== 4'd5) begin
      errors++;
      $display("FAIL oneshot_load: got %0d want 5", cnt_o[0]);
    end
    up_dn = 1'b1; oneshot = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k >= 5) en = ~en;
      tick();
      checks++;
      if (cnt_o[0] !== 4'(m_cnt[0]) || done_o[0] !== m_done[0] || wrap_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL oneshot step %0d: got cnt=%0d done=%b wrap=%b want cnt=%0d done=%b wrap=0",
                 k, cnt_o[0], done_o[0], wrap_o[0], m_cnt[0], m_done[0]);
      end
    end
    checks++;
    if (cnt_o[0] !== 4'd7 || done_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_halt: got cnt=%0d done=%b want cnt=7 done=1", cnt_o[0], done_o[0]);
    end
    oneshot = 1'b0; en = 1'b1; tick();
    checks++;
    if (cnt_o[0] !== 4'd7 || done_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_off_still_halted: got cnt=%0d done=%b want 7/1", cnt_o[0], done_o[0]);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++;
    if (cnt_o[0] !== 4'd0 || done_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_clr: got cnt=%0d done=%b want 0/0", cnt_o[0], done_o[0]);
    end
  endtask

  task automatic test_load_clr();
    en = 1'b1; up_dn = 1'b1; oneshot = 1'b0;
    tick(); tick();
    lv = 9; load = 1'b1; clr = 1'b1; tick(); clr = 1'b0;
    checks++;
    if (cnt_o[1] !== 4'd0 || lerr_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL clr_over_load: got cnt=%0d lerr=%b want 0/0", cnt_o[1], lerr_o[1]);
    end
    lv = 12; tick(); load = 1'b0; en = 1'b0;
    checks++;
    if (cnt_o[1] !== 4'd0 || lerr_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL load_oob: got cnt=%0d lerr=%b want 0/1", cnt_o[1], lerr_o[1]);
    end
    tick();
    checks++;
    if (lerr_o[1] !== 1'b0 || cnt_o[0] !== 4'(m_cnt[0])) begin
      errors++;
      $display("FAIL load_err_pulse: got lerr=%b cnt8=%0d want lerr=0 cnt8=%0d",
               lerr_o[1], cnt_o[0], m_cnt[0]);
    end
  endtask

  task automatic test_async_reset();
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1; up_dn = 1'b1; oneshot = 1'b0;
    repeat (4) tick();
    checks++;
    if (cnt_o[0] !== 4'd4) begin
      errors++;
      $display("FAIL pre_reset_count: got %0d want 4", cnt_o[0]);
    end
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cnt_o[i] !== 4'd0 || wrap_o[i] !== 1'b0 || done_o[i] !== 1'b0 || lerr_o[i] !== 1'b0)
      begin
        errors++;
        $display("FAIL async_reset[%0d]: got cnt=%0d wrap=%b done=%b lerr=%b want all zero",
                 i, cnt_o[i], wrap_o[i], done_o[i], lerr_o[i]);
      end
    end
    model_reset();
    #1 rst = 1'b0;
    tick();
    checks++;
    if (cnt_o[0] !== 4'd1 || cnt_o[1] !== 4'd1) begin
      errors++;
      $display("FAIL post_reset_first: got %0d/%0d want 1/1", cnt_o[0], cnt_o[1]);
    end
  endtask

`ifdef MOD_COUNTER_SATURATE_EN
  task automatic test_saturate();
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1; up_dn = 1'b1; oneshot = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k == 11) up_dn = 1'b0;
      tick();
      checks++;
      if (cnt_o[0] !== 4'(m_cnt[0]) || wrap_o[0] !== 1'b0 || done_o[0] !== 1'b0
          || tc_o[0] !== exp_tc(0)) begin
        errors++;
        $display("FAIL saturate step %0d: got cnt=%0d wrap=%b done=%b tc=%b want cnt=%0d tc=%b",
                 k, cnt_o[0], wrap_o[0], done_o[0], tc_o[0], m_cnt[0], exp_tc(0));
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      clr     = ($urandom_range(0, 19) == 0);
      load    = ($urandom_range(0, 9) == 0);
      en      = ($urandom_range(0, 9) != 0);
      up_dn   = ($urandom_range(0, 2) != 0);
      oneshot = ($urandom_range(0, 3) == 0);
      lv      = int'($urandom_range(0, 15));
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (cnt_o[i] !== 4'(m_cnt[i]) || tc_o[i] !== exp_tc(i) || wrap_o[i] !== m_wrap[i]
            || done_o[i] !== m_done[i] || lerr_o[i] !== m_lerr[i]) begin
          errors++;
          $display("FAIL random[%0d] cyc %0d: got cnt=%0d tc=%b wrap=%b done=%b lerr=%b want cnt=%0d tc=%b wrap=%b done=%b lerr=%b",
                   i, k, cnt_o[i], tc_o[i], wrap_o[i], done_o[i], lerr_o[i],
                   m_cnt[i], exp_tc(i), m_wrap[i], m_done[i], m_lerr[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_oneshot();
    test_load_clr();
    test_async_reset();
`ifdef MOD_COUNTER_SATURATE_EN
    test_saturate();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
